// File: rtl/fxp_mult_pipe.sv
// fxp_mult_pipe: 4-stage pipelined two's-complement fixed-point multiplier with round-half-up rescale and overflow flag
// Ports: clk, reset (asynchronous, active-high)
//        in_valid/in_ready, a_in, b_in, tag_in   operand side
//        out_valid/out_ready, y_out, tag_out, ovf_out   result side
// Every stage advances together whenever the output register is empty or is being drained,
// so a stall freezes the whole pipe, bubbles included.
// Build option FXP_MULT_SAT_EN: clamp y_out on overflow instead of wrapping.
module fxp_mult_pipe #(
    parameter int A_W        = 16,
    parameter int B_W        = 16,
    parameter int FRAC_SHIFT = 15,
    parameter int OUT_W      = 16,
    parameter int TAG_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a_in,
    input  logic [B_W-1:0]   b_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             ovf_out
);
    localparam int PW = A_W + B_W;
    localparam int RW = PW + 1 - FRAC_SHIFT;
    // Half an output LSB; shifting right once makes FRAC_SHIFT=0 yield zero.
    localparam logic [PW:0] RND = ({{PW{1'b0}}, 1'b1} << FRAC_SHIFT) >> 1;

    logic             adv;
    logic             v1, v2, v3;
    logic [A_W-1:0]   a1, ma2;
    logic [B_W-1:0]   b1, mb2;
    logic [TAG_W-1:0] t1, t2, t3;
    logic             s2, s3;
    logic [PW-1:0]    m3, p;
    logic [PW:0]      pr;
    logic [RW-1:0]    r;
    logic             ovf;
    logic [OUT_W-1:0] y;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // One guard bit keeps the rounding add from overflowing the product width.
    always_comb begin
        p   = s3 ? -m3 : m3;
        pr  = {p[PW-1], p} + RND;
        r   = RW'($signed(pr) >>> FRAC_SHIFT);
        ovf = ~(&r[RW-1:OUT_W-1] | ~|r[RW-1:OUT_W-1]);
`ifdef FXP_MULT_SAT_EN
        y   = ovf ? {r[RW-1], {(OUT_W-1){~r[RW-1]}}} : r[OUT_W-1:0];
`else
        y   = r[OUT_W-1:0];
`endif
    end

    // Negating in the operand's own width maps -2^(W-1) onto magnitude 2^(W-1) exactly.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            t1        <= '0;
            t2        <= '0;
            t3        <= '0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            ma2       <= '0;
            mb2       <= '0;
            m3        <= '0;
            out_valid <= 1'b0;
            y_out     <= '0;
            tag_out   <= '0;
            ovf_out   <= 1'b0;
        end else if (adv) begin
            v1        <= in_valid;
            a1        <= a_in;
            b1        <= b_in;
            t1        <= tag_in;
            v2        <= v1;
            s2        <= a1[A_W-1] ^ b1[B_W-1];
            ma2       <= a1[A_W-1] ? -a1 : a1;
            mb2       <= b1[B_W-1] ? -b1 : b1;
            t2        <= t1;
            v3        <= v2;
            s3        <= s2;
            m3        <= PW'(ma2) * PW'(mb2);
            t3        <= t2;
            out_valid <= v3;
            y_out     <= y;
            tag_out   <= t3;
            ovf_out   <= ovf;
        end
endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb_fxp_mult_pipe: directed and randomized check of fxp_mult_pipe against an integer reference model
module tb_fxp_mult_pipe;
    localparam int A_W   = 16;
    localparam int B_W   = 16;
    localparam int FS    = 15;
    localparam int OUT_W = 16;
    localparam int TAG_W = 2;

    typedef struct {
        logic [OUT_W-1:0] y;
        logic             ovf;
        logic [TAG_W-1:0] t;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [A_W-1:0]   a_in = '0;
    logic [B_W-1:0]   b_in = '0;
    logic [TAG_W-1:0] tag_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] y_out;
    logic [TAG_W-1:0] tag_out;
    logic             ovf_out;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   sent;
    int   got;
    exp_t q[$];

    fxp_mult_pipe #(.A_W(A_W), .B_W(B_W), .FRAC_SHIFT(FS), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .y_out(y_out), .tag_out(tag_out), .ovf_out(ovf_out)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Exact product, rounded by flooring (p + half LSB); floor division is an arithmetic shift on longint.
    function automatic exp_t model(logic [A_W-1:0] a, logic [B_W-1:0] b, logic [TAG_W-1:0] t);
        exp_t   e;
        longint p  = longint'($signed(a)) * longint'($signed(b));
        longint r  = (p + ((longint'(1) << FS) >>> 1)) >>> FS;
        longint hi = (longint'(1) << (OUT_W - 1)) - 1;
        longint lo = -(longint'(1) << (OUT_W - 1));
        e.ovf = (r > hi) || (r < lo);
`ifdef FXP_MULT_SAT_EN
        e.y   = e.ovf ? (r > 0 ? OUT_W'(hi) : OUT_W'(lo)) : OUT_W'(r);
`else
        e.y   = OUT_W'(r);
`endif
        e.t   = t;
        return e;
    endfunction

    task automatic direct(string nm, logic [15:0] a, logic [15:0] b, logic [15:0] ey, logic eo);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        tag_in    = 2'd1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_lat"}, lat, 4);
        check({nm, "_y"}, y_out, ey);
        check({nm, "_ovf"}, ovf_out, eo);
        check({nm, "_tag"}, tag_out, 1);
    endtask

    task automatic flush();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic cyc(logic iv, logic ordy, logic [TAG_W-1:0] t);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        a_in      = ($urandom % 8 == 0) ? {1'b1, {(A_W-1){1'b0}}} : A_W'($urandom);
        b_in      = ($urandom % 8 == 0) ? {1'b1, {(B_W-1){1'b0}}} : B_W'($urandom);
        tag_in    = t;
        #1;
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid) begin
            if (q.size() == 0) check("spurious_valid", out_valid, 0);
            else begin
                check("y", y_out, q[0].y);
                check("ovf", ovf_out, q[0].ovf);
                check("tag", tag_out, q[0].t);
                if (out_ready) begin
                    void'(q.pop_front());
                    got++;
                end
            end
        end
        if (iv && in_ready) begin
            q.push_back(model(a_in, b_in, t));
            sent++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_y", y_out, 0);
        check("rst_tag", tag_out, 0);
        check("rst_ovf", ovf_out, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        direct("half_sq", 16'h4000, 16'h4000, 16'h2000, 1'b0);
        direct("half_neg", 16'h4000, 16'hC000, 16'hE000, 1'b0);
`ifdef FXP_MULT_SAT_EN
        direct("min_sq", 16'h8000, 16'h8000, 16'h7FFF, 1'b1);
`else
        direct("min_sq", 16'h8000, 16'h8000, 16'h8000, 1'b1);
`endif
        direct("min_max", 16'h8000, 16'h7FFF, 16'h8001, 1'b0);
        direct("rnd_up", 16'h0001, 16'h4000, 16'h0001, 1'b0);
        direct("rnd_neg", 16'hFFFF, 16'h4000, 16'h0000, 1'b0);
        direct("zero", 16'h0000, 16'h8000, 16'h0000, 1'b0);
        flush();

        sent = 0;
        got  = 0;
        for (int c = 0; c < 30; c++) cyc(sent < 8, !(c >= 6 && c <= 9), TAG_W'(sent % 4));
        check("bp_sent", sent, 8);
        check("bp_got", got, 8);
        check("bp_left", q.size(), 0);

        sent = 0;
        got  = 0;
        for (int c = 0; c < 10000; c++) cyc($urandom % 4 != 0, $urandom % 4 != 0, TAG_W'($urandom));
        for (int c = 0; c < 50 && q.size() > 0; c++) cyc(1'b0, 1'b1, '0);
        check("rand_left", q.size(), 0);
        check("rand_count", got, sent);

        flush();
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, TAG_W'(c));
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_valid_before", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_valid", out_valid, 0);
        check("mid_y", y_out, 0);
        check("mid_ovf", ovf_out, 0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        direct("post_rst", 16'h4000, 16'hC000, 16'hE000, 1'b0);
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fxp_mult_pipe.md
Name: fxp_mult_pipe

Overview:
- Parametrised, fully pipelined two's-complement fixed-point multiplier with valid/ready handshake on input and output.
- Generalises the team's fixed 16x16 sign-magnitude multiplier:
  - independent operand widths
  - correct handling of the most-negative operand
  - fractional rescale with round-half-up
  - overflow detection
  - tag passthrough and back-pressure
- Used in the Box-Muller datapath, for example sqrt(-2ln u1) x cos(2pi u2), with the tag carrying the channel (cos/sin) ID.

Parameters:
- A_W, 16, operand A width, signed; range 2..32.
- B_W, 16, operand B width, signed; range 2..32.
- FRAC_SHIFT, 15, arithmetic right shift applied to the full product; 0 disables rounding.
- OUT_W, 16, result width, signed; must satisfy OUT_W <= A_W+B_W-FRAC_SHIFT.
- TAG_W, 2, sideband tag width carried alongside each sample.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operand pair valid.
- in_ready, output, 1, block accepts operands this cycle.
- a_in, input, A_W, signed operand A.
- b_in, input, B_W, signed operand B.
- tag_in, input, TAG_W, sideband tag.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts result.
- y_out, output, OUT_W, signed scaled product.
- tag_out, output, TAG_W, tag aligned with y_out.
- ovf_out, output, 1, the rounded, shifted product did not fit in OUT_W; aligned with y_out.

Behaviour:
- Reset (async assert, released synchronously by clk): all stage valids cleared. y_out=0, tag_out=0, ovf_out=0, out_valid=0. in_ready reads 1 one cycle after reset release.
- Reset mid-operation: every in-flight sample is discarded, with no partial output.
- Pipeline advance:
  - adv = ~out_valid | out_ready.
  - in_ready = adv, combinational.
  - When adv=0, every stage holds its contents, including bubbles.
  - When adv=1, every stage shifts by one.
- Input transfer occurs on in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters.
- Latency: 4 adv-cycles from accepted input to out_valid. Throughput is 1 sample/cycle while out_ready=1.
- Stage S1: register a_in, b_in, tag_in and valid.
- Stage S2:
  - sign = a[A_W-1] ^ b[B_W-1].
  - Magnitudes are A_W and B_W bits wide, unsigned. The most-negative value is converted exactly: -2^(A_W-1) gives magnitude 2^(A_W-1).
- Stage S3: unsigned magnitude product of A_W+B_W bits; sign and tag piped alongside.
- Stage S4:
  - p = sign ? -mag : mag, as A_W+B_W-bit signed.
  - r = (p + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, arithmetic shift; when FRAC_SHIFT=0, r = p.
  - Rounding is round-half-toward-+inf.
  - ovf = r outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - y_out = r[OUT_W-1:0], wrap, unless the optional feature is enabled.
  - Registered into y_out, tag_out, ovf_out, out_valid.
- Output hold: while out_valid=1 and out_ready=0, y_out, tag_out and ovf_out are stable, and in_ready=0.
- Zero operand gives y_out=0 with no sign artefact (no negative zero).
- Simultaneous output handshake and new input in the same cycle is legal, with no bubble inserted.
- Bubbles within the pipe are not collapsed while stalled. This is acceptable; there is no loss and no duplication.

Optional Feature:
- Macro: FXP_MULT_SAT_EN.
- Defined: on ovf, y_out clamps to 2^(OUT_W-1)-1 for positive r, or -2^(OUT_W-1) for negative r. ovf_out is still asserted.
- Undefined: y_out is the wrapped low OUT_W bits of r. ovf_out behaves the same in both builds.

Test Plan (defaults: A_W=B_W=OUT_W=16, FRAC_SHIFT=15):
- Q1.15 basics: a=0x4000, b=0x4000 → y=0x2000, ovf=0. a=0x4000, b=0xC000 → y=0xE000, ovf=0. out_valid exactly 4 cycles after accept.
- Most-negative: a=0x8000, b=0x8000 → ovf=1. y=0x8000 without FXP_MULT_SAT_EN; y=0x7FFF with it. a=0x8000, b=0x7FFF → y=0x8001, ovf=0.
- Rounding: a=0x0001, b=0x4000 → y=0x0001. a=0xFFFF, b=0x4000 → y=0x0000. a=0x0000, b=0x8000 → y=0x0000.
- Back-pressure:
  - Stimulus: stream 8 tagged samples (tag=i%4) with out_ready low for cycles 6-9.
  - Response: in_ready low while stalled, y_out stable, all 8 results in order with correct tags, no drops or duplicates.
- Reset mid-flight: assert reset with 3 samples in the pipe → out_valid=0 and y_out=0 immediately (asynchronous). After release, the first new sample emerges after 4 cycles and no stale data appears.
- Random sweep: 10k random signed pairs with random in_valid/out_ready → compare against a reference model (round-half-up, wrap or saturate per build).
